// File: rtl/fetch_queue.sv
// Instruction fetch stage with a prefetch queue between a synchronous ROM and decode.
// It has a valid/ready output, a one-cycle redirect flush and a saturating redirect counter.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              ROM_AW   = 8,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [ROM_AW-1:0] rom_address,
   input  logic [XLEN-1:0]   rom_data,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_instr,
   output logic [XLEN-1:0]   out_pc,
   output logic [15:0]       flush_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] inflight_pc;
   logic            inflight;
   logic [CW-1:0]   count;
   logic [CW-1:0]   occupancy;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [XLEN-1:0] mem_instr [DEPTH];
   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic            issue;
   logic            capture;
   logic            pop;
   logic            not_empty;

   // Reservation counts the word in flight so a capture always finds a free slot.
   assign occupancy = count + CW'(inflight);
   assign issue     = enable && !redirect && (occupancy < CW'(DEPTH));
   assign capture   = inflight && !redirect;
   assign pop       = out_valid && out_ready && !redirect;
   assign not_empty = (count != '0);

   assign rom_address = fetch_pc[ROM_AW+1:2];
   assign out_valid   = enable && not_empty;
   assign out_instr   = not_empty ? mem_instr[rd_ptr] : NOP;
   assign out_pc      = not_empty ? mem_pc[rd_ptr]    : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         flush_count <= '0;
      end else if (redirect) begin
         fetch_pc    <= redirect_target & ~{{(XLEN-2){1'b0}}, 2'b11};
         inflight    <= 1'b0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + XLEN'(4);
         end
         if (capture) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         case ({capture, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: queue storage has no reset; count gates every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         mem_instr[wr_ptr] <= rom_data;
         mem_pc[wr_ptr]    <= inflight_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic.
// Every cycle is compared against a queue-level reference model.
module tb_fetch_queue;

   localparam int          XLEN   = 32;
   localparam int          ROM_AW = 8;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic [ROM_AW-1:0] rom_address;
   logic [XLEN-1:0]   rom_data = '0;
   logic              redirect = 1'b0;
   logic [XLEN-1:0]   redirect_target = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [XLEN-1:0]   out_instr;
   logic [XLEN-1:0]   out_pc;
   logic [15:0]       flush_count;

   fetch_queue #(.XLEN(XLEN), .ROM_AW(ROM_AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .enable(enable), .rom_address(rom_address),
      .rom_data(rom_data), .redirect(redirect), .redirect_target(redirect_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   logic [XLEN-1:0] rom [256];
   always @(posedge clk) rom_data <= rom[rom_address];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      m_q[$];
   logic [31:0] m_fetch = '0;
   logic [31:0] m_infl_pc = '0;
   bit          m_infl = 1'b0;
   int          m_flush = 0;
   bit          checking = 1'b0;

   int tests = 0;
   int fails = 0;

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      logic [7:0] idx;
      idx = pc[9:2];
      return rom[idx];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, compare outputs with the model, then advance the model.
   task automatic cycle(input bit r, input bit en, input bit rd, input bit redir,
                        input logic [31:0] tgt);
      bit do_pop;
      bit do_issue;
      @(negedge clk);
      rst = r; enable = en; out_ready = rd; redirect = redir; redirect_target = tgt;
      #1;
      if (checking) begin
         check("out_valid", {31'd0, out_valid}, {31'd0, en && (m_q.size() > 0)});
         check("out_instr", out_instr, (m_q.size() > 0) ? m_q[0].instr : NOP);
         check("out_pc", out_pc, (m_q.size() > 0) ? m_q[0].pc : 32'd0);
         check("rom_address", {24'd0, rom_address}, {24'd0, m_fetch[9:2]});
         check("flush_count", {16'd0, flush_count}, m_flush);
      end
      @(posedge clk);
      if (r) begin
         m_q.delete(); m_infl = 0; m_fetch = '0; m_flush = 0;
      end else if (redir) begin
         m_q.delete(); m_infl = 0;
         m_fetch = {tgt[31:2], 2'b00};
         if (m_flush < 65535) m_flush++;
      end else begin
         do_pop   = en && rd && (m_q.size() > 0);
         do_issue = en && ((m_q.size() + int'(m_infl)) < DEPTH);
         if (do_pop) void'(m_q.pop_front());
         if (m_infl) m_q.push_back('{pc: m_infl_pc, instr: rom_word(m_infl_pc)});
         m_infl = do_issue;
         if (do_issue) begin
            m_infl_pc = m_fetch;
            m_fetch   = m_fetch + 32'd4;
         end
      end
      checking = 1'b1;
      #2;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'h100 + i;

      // Reset, then stream with decode always ready
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_instr", out_instr, NOP);
      check("rst_flush", {16'd0, flush_count}, 32'd0);
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 1, 0, 0);
      check("first_valid", {31'd0, out_valid}, 32'd1);
      check("first_pc", out_pc, 32'h0);
      check("first_instr", out_instr, 32'h100);
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0);

      // Backpressure fills the queue to its reservation limit
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0);
      check("bp_rom_addr", {24'd0, rom_address}, 32'd4);
      check("bp_head_pc", out_pc, 32'h0);
      for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0);

      // Redirect with three queued entries and one word in flight
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 1, 32'h40);
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 1, 0, 0);
      check("redir_pc", out_pc, 32'h40);
      check("redir_instr", out_instr, 32'h110);
      check("redir_flush", {16'd0, flush_count}, 32'd1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);

      // Misaligned target issued together with an attempted pop
      cycle(0, 1, 1, 1, 32'h43);
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 1, 0, 0);
      check("redir43_pc", out_pc, 32'h40);
      check("redir43_flush", {16'd0, flush_count}, 32'd2);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);

      // Enable low mid-stream, then resume
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0);

      // Reset with fetch_pc at 0x3FC and a word in flight
      cycle(0, 1, 1, 1, 32'h3F0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
      check("pre_rst_addr", {24'd0, rom_address}, 32'd255);
      cycle(1, 1, 1, 0, 0);
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_addr", {24'd0, rom_address}, 32'd0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0);

      // Stream across the ROM address wrap
      cycle(0, 1, 1, 1, 32'h3F8);
      for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0);

      // Random traffic
      for (int i = 0; i < 600; i++)
         cycle(($urandom % 64) == 0, ($urandom % 8) != 0, ($urandom % 4) != 0,
               ($urandom % 16) == 0, $urandom);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
